// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Request/acknowledge controller for a clock-gate cell. A consumer raises REQ
// to get its gated clock domain; the controller turns the gate enable on, waits
// WAKE_CYCLES for the gated clock to settle, then acknowledges. When the
// request goes away the enable is kept on for IDLE_CYCLES consecutive idle
// cycles so short request gaps do not pay the wake cost again. FORCE_ON keeps
// the enable on (for test/debug) but never acknowledges a requester.
//
// Parameters
//   WAKE_CYCLES  cycles CLK_EN is high before ACK asserts (1 .. 2**CNT_W)
//   IDLE_CYCLES  consecutive idle cycles in HOLD before CLK_EN drops
//                (1 .. 2**CNT_W)
//   CNT_W        width of the counter shared by the wake and idle phases
//
// Ports
//   clk       in   free-running clock, never gated by this block
//   RST       in   asynchronous active-low reset
//   REQ       in   consumer requests its gated clock domain (sync to clk)
//   FORCE_ON  in   test/debug override that keeps the enable on
//   CLK_EN    out  enable to the clock-gate cell
//   ACK       out  gated clock is stable and usable by the requester
//
// Both outputs come straight from flops, so they only move just after a
// rising clk edge and are stable through the gate latch's transparent
// (clk low) phase; there is no path from any input to any output.
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned IDLE_CYCLES = 8,
   parameter int unsigned CNT_W       = 4
) (
   input  logic clk,
   input  logic RST,
   input  logic REQ,
   input  logic FORCE_ON,
   output logic CLK_EN,
   output logic ACK
);

   // Terminal counter values. A count of 2**CNT_W cycles ends at the all-ones
   // value, so the full legal parameter range fits in CNT_W bits.
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             clk_en_q;
   logic             clk_en_nxt;
   logic             ack_q;
   logic             ack_nxt;

   // Counter advance that holds at the terminal value instead of wrapping.
   function automatic logic [CNT_W-1:0] cnt_sat_inc(
      input logic [CNT_W-1:0] c,
      input logic [CNT_W-1:0] last
   );
      return (c == last) ? c : c + 1'b1;
   endfunction

   // Next-state, next-count and next-output logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;

      unique case (state)
         ST_OFF: begin
            if (REQ || FORCE_ON) begin
               state_nxt = ST_WAKE;
               cnt_nxt   = '0;
            end
         end

         // REQ is only looked at on the last wake cycle: a request that drops
         // part way through still completes the wake and then idles in HOLD.
         ST_WAKE: begin
            if (cnt == WAKE_LAST) begin
               cnt_nxt = '0;
               if (REQ) state_nxt = ST_ON;
               else     state_nxt = ST_HOLD;
            end else begin
               cnt_nxt = cnt_sat_inc(cnt, WAKE_LAST);
            end
         end

         ST_ON: begin
            if (!REQ) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end
         end

         // The clock is still running here, so a returning request is
         // acknowledged directly without another wake. FORCE_ON restarts the
         // idle count every cycle it is high.
         ST_HOLD: begin
            if (REQ) begin
               state_nxt = ST_ON;
               cnt_nxt   = '0;
            end else if (FORCE_ON) begin
               cnt_nxt = '0;
            end else if (cnt == IDLE_LAST) begin
               state_nxt = ST_OFF;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_sat_inc(cnt, IDLE_LAST);
            end
         end

         default: begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
         end
      endcase

      // Outputs are decoded from the next state and registered alongside it,
      // so each output is a single flop and cannot glitch on a state change.
      clk_en_nxt = (state_nxt != ST_OFF);
      ack_nxt    = (state_nxt == ST_ON);
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state    <= ST_OFF;
         cnt      <= '0;
         clk_en_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         clk_en_q <= clk_en_nxt;
         ack_q    <= ack_nxt;
      end
   end

   assign CLK_EN = clk_en_q;
   assign ACK    = ack_q;

`ifndef SYNTHESIS
   // The requester may only be told the clock is usable while it is enabled.
   a_ack_implies_en : assert property (
      @(posedge clk) disable iff (!RST) ACK |-> CLK_EN);

   a_ack_only_on : assert property (
      @(posedge clk) disable iff (!RST) ACK |-> (state == ST_ON));

   a_wake_cnt_bound : assert property (
      @(posedge clk) disable iff (!RST) (state == ST_WAKE) |-> (cnt <= WAKE_LAST));

   a_hold_cnt_bound : assert property (
      @(posedge clk) disable iff (!RST) (state == ST_HOLD) |-> (cnt <= IDLE_LAST));

   a_en_matches_state : assert property (
      @(posedge clk) disable iff (!RST) CLK_EN == (state != ST_OFF));
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//
// Three controllers with different parameter sets share one stimulus stream:
//   u0  defaults          (WAKE=2, IDLE=8, CNT_W=4)
//   u1  shortest timing   (WAKE=1, IDLE=1, CNT_W=4)
//   u2  full counter span (WAKE=4, IDLE=4, CNT_W=2)
// Each is compared every cycle against a reference model that tracks
// "enabled", "acknowledged", "wake cycles still to go" and "idle cycles seen".
// -----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

   localparam int NI = 3;
   localparam int WC [NI] = '{2, 1, 4};
   localparam int IC [NI] = '{8, 1, 4};

   logic          clk;
   logic          RST;
   logic          REQ;
   logic          FORCE_ON;
   logic [NI-1:0] en_w;
   logic [NI-1:0] ack_w;

   int n_cmp = 0;
   int n_err = 0;

   clk_gate_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(8), .CNT_W(4)) u0 (
      .clk(clk), .RST(RST), .REQ(REQ), .FORCE_ON(FORCE_ON),
      .CLK_EN(en_w[0]), .ACK(ack_w[0]));

   clk_gate_ctrl #(.WAKE_CYCLES(1), .IDLE_CYCLES(1), .CNT_W(4)) u1 (
      .clk(clk), .RST(RST), .REQ(REQ), .FORCE_ON(FORCE_ON),
      .CLK_EN(en_w[1]), .ACK(ack_w[1]));

   clk_gate_ctrl #(.WAKE_CYCLES(4), .IDLE_CYCLES(4), .CNT_W(2)) u2 (
      .clk(clk), .RST(RST), .REQ(REQ), .FORCE_ON(FORCE_ON),
      .CLK_EN(en_w[2]), .ACK(ack_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      bit en;
      bit ack;
      int wake;   // wake cycles still to run; 0 when not waking
      int idle;   // consecutive idle cycles seen while enabled but not acked
   } mdl_t;

   mdl_t mdl [NI];

   function automatic mdl_t mdl_zero();
      mdl_t z;
      z.en = 1'b0; z.ack = 1'b0; z.wake = 0; z.idle = 0;
      return z;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t s, input bit r, input bit f,
                                     input int wc, input int ic);
      mdl_t n;
      n = s;
      if (!s.en) begin
         if (r || f) begin
            n.en   = 1'b1;
            n.wake = wc;
         end
      end else if (s.wake > 0) begin
         n.wake = s.wake - 1;
         if (n.wake == 0) begin
            if (r) n.ack  = 1'b1;
            else   n.idle = 0;
         end
      end else if (s.ack) begin
         if (!r) begin
            n.ack  = 1'b0;
            n.idle = 0;
         end
      end else begin
         if (r)      n.ack  = 1'b1;
         else if (f) n.idle = 0;
         else begin
            n.idle = s.idle + 1;
            if (n.idle >= ic) begin
               n.en   = 1'b0;
               n.idle = 0;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < NI; k++) mdl[k] <= mdl_zero();
      end else begin
         for (int k = 0; k < NI; k++)
            mdl[k] <= mdl_step(mdl[k], REQ, FORCE_ON, WC[k], IC[k]);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cmp_all(input string tag);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s_en%0d", tag, k),  int'(en_w[k]),  int'(mdl[k].en));
         check($sformatf("%s_ack%0d", tag, k), int'(ack_w[k]), int'(mdl[k].ack));
      end
   endtask

   // Apply inputs just after a falling edge, let one rising edge sample them,
   // then look at the outputs on the following falling edge.
   task automatic cyc(input bit r, input bit f, input string tag);
      REQ      = r;
      FORCE_ON = f;
      @(posedge clk);
      @(negedge clk);
      cmp_all(tag);
   endtask

   // Reset pulse placed in the low phase, well away from any rising edge.
   task automatic async_rst(input string tag);
      #2;
      RST = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s_en%0d", tag, k),  int'(en_w[k]),  0);
         check($sformatf("%s_ack%0d", tag, k), int'(ack_w[k]), 0);
      end
      @(negedge clk);
      RST = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RST      = 1'b0;
      REQ      = 1'b0;
      FORCE_ON = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_en0", int'(en_w[0]), 0);
      check("rst_ack0", int'(ack_w[0]), 0);
      cmp_all("rst");
      RST = 1'b1;

      // Wake latency from OFF.
      cyc(1'b1, 1'b0, "wk0");
      check("wk0_en", int'(en_w[0]), 1);
      check("wk0_ack", int'(ack_w[0]), 0);
      check("wk0_u1_ack", int'(ack_w[1]), 0);
      cyc(1'b1, 1'b0, "wk1");
      check("wk1_ack", int'(ack_w[0]), 0);
      check("wk1_u1_ack", int'(ack_w[1]), 1);
      cyc(1'b1, 1'b0, "wk2");
      check("wk2_ack", int'(ack_w[0]), 1);
      cyc(1'b1, 1'b0, "on");

      // Request drop: ACK off at once, enable kept for the idle window.
      cyc(1'b0, 1'b0, "drop0");
      check("drop0_ack", int'(ack_w[0]), 0);
      check("drop0_en", int'(en_w[0]), 1);
      check("drop0_u1_en", int'(en_w[1]), 1);
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b0, 1'b0, "idle");
         check($sformatf("idle%0d_en", i), int'(en_w[0]), 1);
         if (i == 1) check("idle1_u1_en", int'(en_w[1]), 0);
      end
      cyc(1'b0, 1'b0, "idle8");
      check("idle8_en", int'(en_w[0]), 0);

      // Return to ON from the middle of HOLD, no re-wake.
      repeat (3) cyc(1'b1, 1'b0, "rewk");
      check("rewk_ack", int'(ack_w[0]), 1);
      repeat (6) cyc(1'b0, 1'b0, "hold5");
      check("hold5_ack", int'(ack_w[0]), 0);
      cyc(1'b1, 1'b0, "hold_req");
      check("hold_req_ack", int'(ack_w[0]), 1);
      cyc(1'b0, 1'b0, "hold2_0");
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b0, 1'b0, "hold2");
         check($sformatf("hold2_%0d_en", i), int'(en_w[0]), 1);
      end
      cyc(1'b0, 1'b0, "hold2_8");
      check("hold2_8_en", int'(en_w[0]), 0);

      // FORCE_ON keeps the clock on without acknowledging.
      cyc(1'b0, 1'b1, "frc0");
      check("frc0_en", int'(en_w[0]), 1);
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b1, "frc");
         check("frc_en", int'(en_w[0]), 1);
         check("frc_ack", int'(ack_w[0]), 0);
      end
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b0, 1'b0, "frcoff");
         check("frcoff_en", int'(en_w[0]), 1);
      end
      cyc(1'b0, 1'b0, "frcoff8");
      check("frcoff8_en", int'(en_w[0]), 0);

      // Asynchronous reset in the middle of a wake, then a full wake again.
      cyc(1'b1, 1'b0, "mw0");
      cyc(1'b1, 1'b0, "mw1");
      async_rst("mwrst");
      cyc(1'b1, 1'b0, "rw0");
      check("rw0_en", int'(en_w[0]), 1);
      check("rw0_ack", int'(ack_w[0]), 0);
      cyc(1'b1, 1'b0, "rw1");
      check("rw1_ack", int'(ack_w[0]), 0);
      cyc(1'b1, 1'b0, "rw2");
      check("rw2_ack", int'(ack_w[0]), 1);
      async_rst("onrst");
      cyc(1'b0, 1'b0, "post_onrst");

      // Randomized segments of held inputs, with occasional reset pulses.
      for (int seg = 0; seg < 400; seg++) begin
         bit r;
         bit f;
         int len;
         r   = ($urandom_range(0, 2) != 0);
         f   = ($urandom_range(0, 5) == 0);
         len = $urandom_range(1, 14);
         for (int i = 0; i < len; i++) begin
            if (i > 0 && $urandom_range(0, 9) == 0) r = ~r;
            cyc(r, f, "rnd");
            if ($urandom_range(0, 199) == 0) async_rst("rndrst");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Bound on total run time in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("FAIL timeout got=%0d exp=%0d", 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning. The block SHALL support each parameter as listed.
- WAKE_CYCLES, 2, cycles CLK_EN is held high before ACK asserts; legal range 1 to 2^CNT_W.
- IDLE_CYCLES, 8, consecutive idle cycles in HOLD before CLK_EN drops; legal range 1 to 2^CNT_W.
- CNT_W, 4, width of the shared wake/idle counter.
REQ-002 Ports, one per line: name, direction, width, meaning. The block SHALL provide exactly these ports.
- clk, input, 1, the single clock; free-running, never gated by this block.
- RST, input, 1, reset; asynchronous, active-low.
- REQ, input, 1, a consumer requests its gated clock domain; synchronous to clk.
- FORCE_ON, input, 1, test/debug override that keeps the clock enabled.
- CLK_EN, output, 1, enable to the clock-gate cell's CLK_EN input.
- ACK, output, 1, the gated clock is stable and usable by the requester.
REQ-003 All outputs SHALL be Moore outputs decoded from registered state only, with no combinational path from any input to any output.

Function
REQ-004 The FSM SHALL have four states: OFF, WAKE, ON and HOLD, plus one counter cnt[CNT_W-1:0].
REQ-005 Output decode SHALL be:
- OFF: CLK_EN=0, ACK=0.
- WAKE: CLK_EN=1, ACK=0.
- ON: CLK_EN=1, ACK=1.
- HOLD: CLK_EN=1, ACK=0.
REQ-006 OFF transitions SHALL be: if REQ=1 or FORCE_ON=1, go to WAKE with cnt=0; else stay in OFF.
REQ-007 WAKE transitions SHALL be:
- If cnt==WAKE_CYCLES-1 and REQ=1, go to ON.
- If cnt==WAKE_CYCLES-1 and REQ=0, go to HOLD with cnt=0.
- Otherwise increment cnt.
- REQ dropping mid-WAKE SHALL NOT abort the wake sequence.
REQ-008 ON transitions SHALL be: if REQ=0, go to HOLD with cnt=0; else stay in ON.
REQ-009 HOLD transitions SHALL be, in this priority:
- If REQ=1, go to ON; no re-wake.
- Else if FORCE_ON=1, stay in HOLD with cnt=0.
- Else if cnt==IDLE_CYCLES-1, go to OFF.
- Otherwise increment cnt.
REQ-010 Latency: with REQ first sampled high at edge n in OFF, CLK_EN SHALL be high after edge n and ACK SHALL be high after edge n+WAKE_CYCLES.
REQ-011 ACK SHALL deassert after the first edge that samples REQ=0 and SHALL reassert after the first edge that samples REQ=1 while in HOLD.
REQ-012 With REQ=0 and FORCE_ON=0 from entry to HOLD at edge m, CLK_EN SHALL fall after edge m+IDLE_CYCLES.
REQ-013 CLK_EN SHALL change only after a rising clk edge, so it is stable during the gate latch's transparent (clk low) phase; CLK_EN SHALL never glitch.
REQ-014 The counter SHALL never wrap: it resets on every state entry and stops at its terminal value.
REQ-015 Simultaneous REQ and FORCE_ON SHALL behave as REQ alone for ACK; FORCE_ON SHALL never assert ACK.

Reset
REQ-016 Reset (RST=0) SHALL asynchronously force state=OFF, cnt=0, CLK_EN=0 and ACK=0, including when asserted mid-WAKE, mid-ON or mid-HOLD.
REQ-017 After RST deasserts, the first state transition SHALL occur at the first rising edge that samples RST=1.
REQ-018 REQ held high through reset release SHALL start a normal wake sequence from OFF.

Verification
REQ-019 With defaults, REQ rises before edge 0 -> CLK_EN=1 after edge 0, ACK=0 after edge 1, ACK=1 after edge 2.
REQ-020 With defaults and state ON, REQ falls before edge 0 with REQ=0 thereafter -> ACK=0 after edge 0, CLK_EN=1 through edge 7, CLK_EN=0 after edge 8.
REQ-021 In HOLD with cnt=5, REQ=1 for one cycle -> state ON with ACK=1 after the next edge, no WAKE visit; a new 8-cycle idle count starts after REQ falls.
REQ-022 With REQ=0 and FORCE_ON=1 from OFF -> CLK_EN=1 after one edge and remains 1 for 100 cycles with ACK=0; FORCE_ON drops -> CLK_EN=0 eight edges later.
REQ-023 RST=0 asserted asynchronously mid-WAKE (cnt=1) -> CLK_EN=0 and ACK=0 immediately, without waiting for a clock edge; after release with REQ=1 -> full 2-cycle wake repeats.
REQ-024 WAKE_CYCLES=1, IDLE_CYCLES=1 -> ACK=1 after edge 1, CLK_EN=0 two edges after REQ falls, and there is no counter wrap.
